// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared widths, client index type and round-robin helper for bram_arbiter
package bram_arb_pkg;

    localparam int BRAM_ABITS  = 11;
    localparam int BRAM_DBITS  = 8;
    localparam int MAX_CLIENTS = 4;

    typedef logic [$clog2(MAX_CLIENTS)-1:0] client_idx_t;

    // Successor of idx in a ring of n clients; a ring of one always returns 0.
    function automatic client_idx_t rr_next(input client_idx_t idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + client_idx_t'(1);
    endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - client command/response bundle between requesters and bram_arbiter
interface bram_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int ABITS    = BRAM_ABITS,
    parameter int DBITS    = BRAM_DBITS
);
    logic [NCLIENTS-1:0]       cmd_valid;
    logic [NCLIENTS-1:0]       cmd_we;
    logic [NCLIENTS*ABITS-1:0] cmd_addr;
    logic [NCLIENTS*DBITS-1:0] cmd_wdata;
    logic [NCLIENTS-1:0]       cmd_ready;
    logic [NCLIENTS-1:0]       rsp_valid;
    logic [DBITS-1:0]          rsp_data;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_arbiter_rr_arbiter.sv
// rtl/bram_arbiter_rr_arbiter.sv - combinational round-robin grant from a pointer, one instance per BRAM port
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  client_idx_t  ptr,
    output logic [N-1:0] gnt,
    output logic         any,
    output client_idx_t  winner,
    output client_idx_t  ptr_next
);

    // First pass scans ptr..N-1, second pass wraps around to 0..ptr-1.
    always_comb begin
        gnt    = '0;
        any    = 1'b0;
        winner = '0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                any    = 1'b1;
                winner = client_idx_t'(j);
                gnt[j] = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                any    = 1'b1;
                winner = client_idx_t'(j);
                gnt[j] = 1'b1;
            end
        end
        ptr_next = any ? rr_next(winner, N) : ptr;
    end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin sharing of a simple dual-port BRAM; BRAM_ARB_RAW_BYPASS_EN forwards same-cycle write data to reads
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NCLIENTS = 2,
    parameter int ABITS    = BRAM_ABITS,
    parameter int DBITS    = BRAM_DBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    bram_arbiter_if.slave    cli,
    output logic             bram_wren,
    output logic [ABITS-1:0] bram_wraddress,
    output logic [DBITS-1:0] bram_data_in,
    output logic             bram_oen,
    output logic [ABITS-1:0] bram_rdaddress,
    input  logic [DBITS-1:0] bram_data_out
);

    logic [NCLIENTS-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
    logic                wr_any, rd_any;
    client_idx_t         wptr, rptr, wptr_nxt, rptr_nxt, wr_win, rd_win;
    logic [NCLIENTS-1:0] rsp_valid_q;

    // Grants are suppressed while reset is held so nothing reaches the BRAM.
    assign wr_req = cli.cmd_valid &  cli.cmd_we & {NCLIENTS{rst_n}};
    assign rd_req = cli.cmd_valid & ~cli.cmd_we & {NCLIENTS{rst_n}};

    rr_arbiter #(.N(NCLIENTS)) u_wr_arb (
        .req      (wr_req),
        .ptr      (wptr),
        .gnt      (wr_gnt),
        .any      (wr_any),
        .winner   (wr_win),
        .ptr_next (wptr_nxt)
    );

    rr_arbiter #(.N(NCLIENTS)) u_rd_arb (
        .req      (rd_req),
        .ptr      (rptr),
        .gnt      (rd_gnt),
        .any      (rd_any),
        .winner   (rd_win),
        .ptr_next (rptr_nxt)
    );

    assign cli.cmd_ready  = wr_gnt | rd_gnt;
    assign bram_wren      = wr_any;
    assign bram_oen       = rd_any;
    assign bram_wraddress = cli.cmd_addr[int'(wr_win)*ABITS +: ABITS];
    assign bram_data_in   = cli.cmd_wdata[int'(wr_win)*DBITS +: DBITS];
    assign bram_rdaddress = cli.cmd_addr[int'(rd_win)*ABITS +: ABITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            rsp_valid_q <= '0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            rsp_valid_q <= rd_gnt;
        end
    end

    assign cli.rsp_valid = rsp_valid_q;

`ifdef BRAM_ARB_RAW_BYPASS_EN
    logic             byp_hit;
    logic [DBITS-1:0] byp_data;

    // The BRAM reads before it writes, so a same-address collision must be forwarded here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= wr_any && rd_any && (bram_wraddress == bram_rdaddress);
            byp_data <= bram_data_in;
        end
    end

    assign cli.rsp_data = byp_hit ? byp_data : bram_data_out;
`else
    assign cli.rsp_data = bram_data_out;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter: vector table, corner sequences, randomized model check
module tb_bram_arbiter;

    localparam int N  = 2;
    localparam int AB = 11;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bram_wren, bram_oen;
    logic [AB-1:0] bram_wraddress, bram_rdaddress;
    logic [DB-1:0] bram_data_in;
    logic [DB-1:0] bram_data_out;

    always #5 clk = ~clk;

    bram_arbiter_if #(.NCLIENTS(N), .ABITS(AB), .DBITS(DB)) bif ();

    bram_arbiter #(.NCLIENTS(N), .ABITS(AB), .DBITS(DB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cli            (bif),
        .bram_wren      (bram_wren),
        .bram_wraddress (bram_wraddress),
        .bram_data_in   (bram_data_in),
        .bram_oen       (bram_oen),
        .bram_rdaddress (bram_rdaddress),
        .bram_data_out  (bram_data_out)
    );

    // Behavioural BRAM: registered read, read-before-write on a collision.
    logic [DB-1:0] bram_mem [0:(1<<AB)-1];
    always @(posedge clk) begin
        if (bram_oen) bram_data_out <= bram_mem[bram_rdaddress];
        if (bram_wren) bram_mem[bram_wraddress] <= bram_data_in;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int            m_wptr, m_rptr;
    logic [DB-1:0] m_mem   [0:(1<<AB)-1];
    bit            m_known [0:(1<<AB)-1];
    logic [N-1:0]  exp_rsp;
    logic [DB-1:0] exp_rsp_data;
    bit            exp_known;

    function automatic logic [AB-1:0] addr_of(input int c);
        return bif.cmd_addr[c*AB +: AB];
    endfunction

    function automatic logic [DB-1:0] wdata_of(input int c);
        return bif.cmd_wdata[c*DB +: DB];
    endfunction

    task automatic model_pre();
        int wwin, rwin, c;
        logic [N-1:0] exp_ready;
        wwin = -1;
        rwin = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_wptr + k) % N;
            if (wwin < 0 && bif.cmd_valid[c] && bif.cmd_we[c]) wwin = c;
            c = (m_rptr + k) % N;
            if (rwin < 0 && bif.cmd_valid[c] && !bif.cmd_we[c]) rwin = c;
        end
        exp_ready = '0;
        if (wwin >= 0) exp_ready[wwin] = 1'b1;
        if (rwin >= 0) exp_ready[rwin] = 1'b1;
        chk("m_ready", bif.cmd_ready, exp_ready);
        chk("m_wren", bram_wren, wwin >= 0);
        chk("m_oen", bram_oen, rwin >= 0);
        if (wwin >= 0) begin
            chk("m_wraddr", bram_wraddress, addr_of(wwin));
            chk("m_wdata", bram_data_in, wdata_of(wwin));
        end
        exp_rsp   = '0;
        exp_known = 0;
        if (rwin >= 0) begin
            chk("m_rdaddr", bram_rdaddress, addr_of(rwin));
            exp_rsp[rwin] = 1'b1;
            exp_rsp_data  = m_mem[addr_of(rwin)];
            exp_known     = m_known[addr_of(rwin)];
`ifdef BRAM_ARB_RAW_BYPASS_EN
            if (wwin >= 0 && addr_of(wwin) == addr_of(rwin)) begin
                exp_rsp_data = wdata_of(wwin);
                exp_known    = 1;
            end
`endif
            m_rptr = (rwin + 1) % N;
        end
        if (wwin >= 0) begin
            m_mem[addr_of(wwin)]   = wdata_of(wwin);
            m_known[addr_of(wwin)] = 1;
            m_wptr = (wwin + 1) % N;
        end
    endtask

    task automatic edge_post();
        @(posedge clk);
        #1;
        chk("m_rsp_valid", bif.rsp_valid, exp_rsp);
        if (exp_rsp != '0 && exp_known) chk("m_rsp_data", bif.rsp_data, exp_rsp_data);
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w,
                         input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                         input logic [DB-1:0] d0, input logic [DB-1:0] d1);
        bif.cmd_valid = v;
        bif.cmd_we    = w;
        bif.cmd_addr  = {a1, a0};
        bif.cmd_wdata = {d1, d0};
    endtask

    task automatic tick();
        #1;
        model_pre();
        edge_post();
    endtask

    function automatic logic [AB-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 11'h7FF;
            1:       return 11'h010;
            default: return AB'($urandom_range(0, 3));
        endcase
    endfunction

    typedef struct {
        logic [N-1:0]  valid, we;
        logic [AB-1:0] a0, a1;
        logic [DB-1:0] d0, d1;
        logic [N-1:0]  ready;
        logic          wren, oen;
        logic [AB-1:0] wraddr, rdaddr;
        logic [N-1:0]  rsp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        for (int i = 0; i < (1 << AB); i++) m_known[i] = 0;
        m_wptr = 0;
        m_rptr = 0;

        tbl[0] = '{2'b00, 2'b00, 11'h100, 11'h200, 8'h20, 8'h30, 2'b00, 1'b0, 1'b0, 11'h000, 11'h000, 2'b00};
        tbl[1] = '{2'b11, 2'b11, 11'h100, 11'h200, 8'h21, 8'h31, 2'b01, 1'b1, 1'b0, 11'h100, 11'h000, 2'b00};
        tbl[2] = '{2'b11, 2'b11, 11'h100, 11'h200, 8'h21, 8'h31, 2'b10, 1'b1, 1'b0, 11'h200, 11'h000, 2'b00};
        tbl[3] = '{2'b01, 2'b01, 11'h100, 11'h200, 8'h23, 8'h33, 2'b01, 1'b1, 1'b0, 11'h100, 11'h000, 2'b00};
        tbl[4] = '{2'b01, 2'b01, 11'h100, 11'h200, 8'h24, 8'h34, 2'b01, 1'b1, 1'b0, 11'h100, 11'h000, 2'b00};
        tbl[5] = '{2'b11, 2'b00, 11'h100, 11'h200, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 11'h000, 11'h100, 2'b01};
        tbl[6] = '{2'b11, 2'b00, 11'h100, 11'h200, 8'h00, 8'h00, 2'b10, 1'b0, 1'b1, 11'h000, 11'h200, 2'b10};
        tbl[7] = '{2'b11, 2'b00, 11'h100, 11'h200, 8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 11'h000, 11'h100, 2'b01};
        tbl[8] = '{2'b11, 2'b01, 11'h100, 11'h200, 8'h28, 8'h00, 2'b11, 1'b1, 1'b1, 11'h100, 11'h200, 2'b10};
        tbl[9] = '{2'b10, 2'b10, 11'h100, 11'h200, 8'h00, 8'h39, 2'b10, 1'b1, 1'b0, 11'h200, 11'h000, 2'b00};

        // Reset with no commands
        rst_n = 1'b0;
        drive('0, '0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bif.rsp_valid, 2'b00);
        chk("rst_wren", bram_wren, 1'b0);
        chk("rst_oen", bram_oen, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d_ready", i), bif.cmd_ready, tbl[i].ready);
            chk($sformatf("tbl%0d_wren", i), bram_wren, tbl[i].wren);
            chk($sformatf("tbl%0d_oen", i), bram_oen, tbl[i].oen);
            if (tbl[i].wren) chk($sformatf("tbl%0d_wraddr", i), bram_wraddress, tbl[i].wraddr);
            if (tbl[i].oen) chk($sformatf("tbl%0d_rdaddr", i), bram_rdaddress, tbl[i].rdaddr);
            model_pre();
            edge_post();
            chk($sformatf("tbl%0d_rsp", i), bif.rsp_valid, tbl[i].rsp);
        end

        // Write then read back through client 0
        drive(2'b01, 2'b01, 11'h010, 11'h000, 8'hA5, 8'h00);
        tick();
        drive(2'b01, 2'b00, 11'h010, 11'h000, 8'h00, 8'h00);
        tick();
        chk("wr_rd_rsp_valid", bif.rsp_valid, 2'b01);
        chk("wr_rd_rsp_data", bif.rsp_data, 8'hA5);

        // Same-address write and read in one cycle
        drive(2'b01, 2'b01, 11'h7FF, 11'h000, 8'h11, 8'h00);
        tick();
        drive(2'b11, 2'b01, 11'h7FF, 11'h7FF, 8'h3C, 8'h00);
        #1;
        chk("raw_ready", bif.cmd_ready, 2'b11);
        model_pre();
        edge_post();
        chk("raw_rsp_valid", bif.rsp_valid, 2'b10);
`ifdef BRAM_ARB_RAW_BYPASS_EN
        chk("raw_rsp_data", bif.rsp_data, 8'h3C);
`else
        chk("raw_rsp_data", bif.rsp_data, 8'h11);
`endif

        // Reset right after a read grant: response killed, pointers back to 0
        drive(2'b01, 2'b00, 11'h010, 11'h000, 8'h00, 8'h00);
        #1;
        chk("prerst_ready", bif.cmd_ready, 2'b01);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_kill_rsp", bif.rsp_valid, 2'b00);
        drive(2'b11, 2'b00, 11'h010, 11'h7FF, 8'h00, 8'h00);
        #1;
        chk("rst_mask_ready", bif.cmd_ready, 2'b00);
        chk("rst_mask_oen", bram_oen, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold_rsp", bif.rsp_valid, 2'b00);
        rst_n  = 1'b1;
        m_wptr = 0;
        m_rptr = 0;
        #1;
        chk("postrst_ready", bif.cmd_ready, 2'b01);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)), pick_addr(), pick_addr(),
                  DB'($urandom), DB'($urandom));
            tick();
        end

        drive('0, '0, '0, '0, '0, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
